// File: rtl/srio_ireq_arb.sv
// Packet-level round-robin arbiter onto the SRIO ireq AXI4-Stream channel; grant costs one idle cycle,
// beats reach m_axis_ireq one cycle after acceptance through a 2-entry output buffer that stalls requesters when full.
module srio_ireq_arb #(
  parameter int N_REQ = 3,
  parameter int DW    = 64,
  parameter int KW    = DW/8,
  parameter int UW    = 32,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [N_REQ-1:0]    cfg_en,
  input  logic [N_REQ-1:0]    s_axis_req_tvalid,
  output logic [N_REQ-1:0]    s_axis_req_tready,
  input  logic [N_REQ*DW-1:0] s_axis_req_tdata,
  input  logic [N_REQ*KW-1:0] s_axis_req_tkeep,
  input  logic [N_REQ-1:0]    s_axis_req_tlast,
  input  logic [N_REQ*UW-1:0] s_axis_req_tuser,
  output logic                m_axis_ireq_tvalid,
  input  logic                m_axis_ireq_tready,
  output logic [DW-1:0]       m_axis_ireq_tdata,
  output logic [KW-1:0]       m_axis_ireq_tkeep,
  output logic                m_axis_ireq_tlast,
  output logic [UW-1:0]       m_axis_ireq_tuser,
  output logic [GW-1:0]       grant_id,
  output logic                busy
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [GW-1:0]      rr_ptr;
  logic [N_REQ-1:0]   cand;
  logic [2*N_REQ-1:0] cand_rot;
  logic [GW-1:0]      sel;
  logic               sel_vld;
  logic [GW:0]        sel_sum;
  beat_t              in_beat, head, tail;
  logic               in_vld;
  logic               push, pop, last_acc;
  logic [1:0]         count, count_nxt;

  assign cand     = s_axis_req_tvalid & cfg_en;
  assign cand_rot = {cand, cand} >> rr_ptr;

  // Rotate candidates so bit 0 is rr_ptr, then take the lowest set bit.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    sel_sum = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!sel_vld && cand_rot[k]) begin
        sel_vld = 1'b1;
        sel_sum = {1'b0, rr_ptr} + (GW+1)'(k);
        if (sel_sum >= (GW+1)'(N_REQ)) sel_sum = sel_sum - (GW+1)'(N_REQ);
        sel = sel_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    in_beat = '0;
    in_vld  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_id == GW'(k)) begin
        in_beat.data = s_axis_req_tdata[k*DW +: DW];
        in_beat.keep = s_axis_req_tkeep[k*KW +: KW];
        in_beat.last = s_axis_req_tlast[k];
        in_beat.user = s_axis_req_tuser[k*UW +: UW];
        in_vld       = s_axis_req_tvalid[k];
      end
    end
  end

  assign push     = (state == LOCKED) && (count != 2'd2) && in_vld;
  assign last_acc = push && in_beat.last;
  assign pop      = m_axis_ireq_tvalid && m_axis_ireq_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_vld) grant_id <= sel;
      if (last_acc) rr_ptr <= (grant_id == GW'(N_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Lock is released only by an accepted tlast; cfg_en/tvalid changes mid-packet are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_vld)  state_nxt = LOCKED;
      LOCKED:  if (last_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axis_req_tready = '0;
    for (int k = 0; k < N_REQ; k++)
      s_axis_req_tready[k] = (state == LOCKED) && (grant_id == GW'(k)) && (count != 2'd2);
    busy = (state == LOCKED) || (count != 2'd0);
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop) count_nxt = count + 2'd1;
    else if (!push && pop) count_nxt = count - 2'd1;
  end

  // head is the output register; tail only holds a beat while head is stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count              <= 2'd0;
      head               <= '0;
      tail               <= '0;
      m_axis_ireq_tvalid <= 1'b0;
    end else begin
      count              <= count_nxt;
      m_axis_ireq_tvalid <= (count_nxt != 2'd0);
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) head <= in_beat;
      else if (pop && count == 2'd2) head <= tail;
      if (push && count == 2'd1 && !pop) tail <= in_beat;
    end
  end

  assign m_axis_ireq_tdata = head.data;
  assign m_axis_ireq_tkeep = head.keep;
  assign m_axis_ireq_tlast = head.last;
  assign m_axis_ireq_tuser = head.user;

endmodule
